// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : simon_pkg
//  Description : Shared types and constants for the Simon Says datapath:
//                colour encoding, history geometry and playback states.
//  Revision    : 1.0 - initial release
// ============================================================================
package simon_pkg;

    localparam int COLOUR_W       = 3;
    localparam int HIST_DEPTH     = 32;
    localparam int UNASSIGNED_BIT = 2;

    typedef logic [COLOUR_W-1:0] colour_t;

    localparam colour_t RED    = 3'd0;
    localparam colour_t GREEN  = 3'd1;
    localparam colour_t BLUE   = 3'd2;
    localparam colour_t YELLOW = 3'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } play_state_t;

endpackage
`default_nettype wire

// File: rtl/colour_onehot.sv
`default_nettype none
// ============================================================================
//  Module      : colour_onehot
//  Description : Maps a 2-bit colour code to the matching one-hot LED pattern.
//                Shared between playback and the player-input checker.
//  Revision    : 1.0 - initial release
// ============================================================================
module colour_onehot (
    input  logic [1:0] colour_i,
    output logic [3:0] onehot_o
);

    // Colour code c lights LED c.
    always_comb begin
        onehot_o = 4'b0001 << colour_i;
    end

endmodule
`default_nettype wire

// File: rtl/sequence_player.sv
`default_nettype none
// ============================================================================
//  Module      : sequence_player
//  Description : Replays the captured colour history on the four LEDs, oldest
//                colour first, with a fixed lit time and dark gap per colour.
//                Reports normal completion (done) and rejected requests or
//                unassigned history entries (error).
//  Revision    : 1.0 - initial release
// ============================================================================
module sequence_player
    import simon_pkg::*;
#(
    parameter int DEPTH      = HIST_DEPTH,
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [$clog2(DEPTH):0]      length,
    input  logic [COLOUR_W*DEPTH-1:0]   segments,
    output logic [3:0]                  led,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int LEN_W   = $clog2(DEPTH) + 1;
    localparam int TMR_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;

    localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_CYCLES - 1);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(DEPTH);

    play_state_t                 state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [TMR_W-1:0]            timer_q, timer_d;
    logic [COLOUR_W*DEPTH-1:0]   snap_q, snap_d;
    logic                        done_q, done_d;
    logic                        error_q, error_d;

    colour_t                     seg_arr  [DEPTH];
    colour_t                     snap_arr [DEPTH];
    logic                        len_ok;
    logic [LEN_W-1:0]            len_m1;
    logic [IDX_W-1:0]            first_idx;
    logic [IDX_W-1:0]            next_idx;
    logic                        next_unassigned;
    colour_t                     cur_entry;
    logic [3:0]                  cur_onehot;

    // Present the packed live history and the snapshot as entry arrays.
    for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
        assign seg_arr[i]  = segments[i*COLOUR_W +: COLOUR_W];
        assign snap_arr[i] = snap_q[i*COLOUR_W +: COLOUR_W];
    end

    assign len_ok    = (length != '0) && (length <= MAX_LEN);
    assign len_m1    = length - LEN_W'(1);
    assign first_idx = IDX_W'(len_m1);

    // The entry about to be lit: from the live history when starting (the
    // snapshot is only loaded at that edge), otherwise from the snapshot.
    assign next_idx        = (state_q == IDLE) ? first_idx : (idx_q - IDX_W'(1));
    assign next_unassigned = (state_q == IDLE) ? seg_arr[next_idx][UNASSIGNED_BIT]
                                               : snap_arr[next_idx][UNASSIGNED_BIT];

    assign cur_entry = snap_arr[idx_q];

    colour_onehot u_onehot (
        .colour_i (cur_entry[1:0]),
        .onehot_o (cur_onehot)
    );

    // An unassigned entry never reaches ON; the extra gate keeps led dark
    // should the snapshot ever hold one at the current index.
    assign led   = ((state_q == ON) && !cur_entry[UNASSIGNED_BIT]) ? cur_onehot : 4'b0000;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign error = error_q;

    // State, counters, snapshot and status pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            timer_q <= '0;
            snap_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            snap_q  <= snap_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Next-state: accept/reject requests, time each lit and dark phase, step
    // the index towards the newest entry and end playback at index 0.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q + TMR_W'(1);
        snap_d  = snap_q;
        done_d  = 1'b0;
        error_d = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (start) begin
                    if (!len_ok) begin
                        error_d = 1'b1;
                    end else begin
                        snap_d = segments;
                        idx_d  = first_idx;
                        if (next_unassigned) begin
                            error_d = 1'b1;
                        end else begin
                            state_d = ON;
                        end
                    end
                end
            end

            ON: begin
                if (timer_q == ON_LAST) begin
                    timer_d = '0;
                    state_d = OFF;
                end
            end

            OFF: begin
                if (timer_q == OFF_LAST) begin
                    timer_d = '0;
                    if (idx_q == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = next_idx;
                        if (next_unassigned) begin
                            error_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = ON;
                        end
                    end
                end
            end

            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
